// File: rtl/pu_sched_pkg.sv
// Shared types and sizing for the PU request scheduler.
// The optional burst mode is selected with the PU_SCHED_BURST_EN macro.
package pu_sched_pkg;

    localparam int NUM_REQ     = 20;
    localparam int REQ_NBITS   = 5;
    localparam int DW          = 32;
    localparam int MAX_OUT     = 4;
    localparam int CNT_NBITS   = 3;
    localparam int BURST_LEN   = 4;
    localparam int BURST_NBITS = 2;

    typedef logic [REQ_NBITS-1:0] req_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        ISSUE = 2'd2
    } sched_state_t;

    // Round-robin successor of a requester id, wrapping the last id to 0.
    function automatic req_id_t next_id(input req_id_t id);
        return (id == req_id_t'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/pu_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible_i at or after ptr_i, wrapping.
module pu_rr_pick
    import pu_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible_i,
    input  req_id_t            ptr_i,
    output logic               found_o,
    output req_id_t            id_o
);

    int      idx;
    req_id_t idx_id;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        found_o = 1'b0;
        id_o    = '0;
        idx     = 0;
        idx_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_id = req_id_t'(idx);
            if (eligible_i[idx_id]) begin
                found_o = 1'b1;
                id_o    = idx_id;
            end
        end
    end

endmodule

// File: rtl/pu_req_sched.sv
// Round-robin scheduler sharing one PU engine among NUM_REQ requesters with a credit limit.
// Define PU_SCHED_BURST_EN to let a still-requesting winner keep the grant up to BURST_LEN times.
module pu_req_sched
    import pu_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_mask,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [REQ_NBITS-1:0]  res_id,
    output logic [DW-1:0]         res_data,
    input  logic                  res_done,
    output logic [CNT_NBITS-1:0]  outstanding,
    output logic                  err_underflow,
    output logic [1:0]            dbg_state
);

    // Issue handshake: res_valid rises in ISSUE and holds res_id/res_data stable until
    // res_ready; the transfer happens on the edge where both are high, and req_ack for
    // that id pulses for exactly one cycle afterwards.

    sched_state_t         state_q, state_d;
    req_id_t              ptr_q, ptr_d;
    req_id_t              id_q, id_d;
    logic [DW-1:0]        data_q, data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [CNT_NBITS-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
`ifdef PU_SCHED_BURST_EN
    logic [BURST_NBITS-1:0] burst_q, burst_d;
`endif

    logic [NUM_REQ-1:0] eligible;
    logic               pick_found;
    req_id_t            pick_id;
    logic [DW-1:0]      pick_data;
    logic               credit;
    logic               hs;

    assign eligible = req_valid & req_mask;
    // A completion in the same cycle frees a slot for this arbitration.
    assign credit   = (cnt_q < CNT_NBITS'(MAX_OUT)) || res_done;
    assign hs       = (state_q == ISSUE) && res_ready;

    pu_rr_pick u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .found_o    (pick_found),
        .id_o       (pick_id)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == req_id_t'(i)) begin
                pick_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!pick_found) begin
                    state_d = IDLE;
                end else if (credit) begin
                    id_d    = pick_id;
                    data_d  = pick_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (res_ready) begin
                    state_d = ARB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        ack_d = '0;
`ifdef PU_SCHED_BURST_EN
        burst_d = burst_q;
`endif
        if (hs) begin
            ack_d[id_q] = 1'b1;
`ifdef PU_SCHED_BURST_EN
            if (eligible[id_q] && (burst_q < BURST_NBITS'(BURST_LEN - 1))) begin
                ptr_d   = id_q;
                burst_d = burst_q + 1'b1;
            end else begin
                ptr_d   = next_id(id_q);
                burst_d = '0;
            end
`else
            ptr_d = next_id(id_q);
`endif
        end
    end

    // A done with nothing in flight is an engine protocol error; the count stays at 0.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (hs && !res_done) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!hs && res_done) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef PU_SCHED_BURST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    assign req_ack       = ack_q;
    assign res_valid     = (state_q == ISSUE);
    assign res_id        = id_q;
    assign res_data      = data_q;
    assign outstanding   = cnt_q;
    assign err_underflow = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pu_req_sched.sv
// Directed bench for pu_req_sched: issue order, credit limit, stall, underflow and reset cases.
// Expected issue order follows PU_SCHED_BURST_EN the same way the design does.
module tb_pu_req_sched;
    import pu_sched_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_mask;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  res_valid;
    logic                  res_ready;
    logic [REQ_NBITS-1:0]  res_id;
    logic [DW-1:0]         res_data;
    logic                  res_done;
    logic [CNT_NBITS-1:0]  outstanding;
    logic                  err_underflow;
    logic [1:0]            dbg_state;

    logic [REQ_NBITS+DW-1:0] exp_q[$];
    int      n_vec = 0;
    int      n_err = 0;
    req_id_t last_id = '0;
    int      mptr = 0;
    int      mburst = 0;

    always #5 clk = ~clk;

    pu_req_sched dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_mask      (req_mask),
        .req_ack       (req_ack),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_id        (res_id),
        .res_data      (res_data),
        .res_done      (res_done),
        .outstanding   (outstanding),
        .err_underflow (err_underflow),
        .dbg_state     (dbg_state)
    );

    function automatic logic [DW-1:0] data_of(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_id(input int i);
        exp_q.push_back({req_id_t'(i), data_of(i)});
    endtask

    // Reference arbiter for phases where every requester keeps requesting.
    task automatic push_model();
        push_id(mptr);
`ifdef PU_SCHED_BURST_EN
        if (mburst < BURST_LEN - 1) begin
            mburst++;
        end else begin
            mburst = 0;
            mptr = (mptr + 1) % NUM_REQ;
        end
`else
        mptr = (mptr + 1) % NUM_REQ;
`endif
    endtask

    task automatic serve(input int n, input bit hold, input bit drop_end, input bit give_done);
        int got = 0;
        int cyc = 0;
        logic [NUM_REQ-1:0] one_hot;
        while (got < n && cyc < n * 4 + 10) begin
            @(posedge clk);
            #1;
            cyc++;
            res_done = 1'b0;
            if (req_ack != '0) begin
                got++;
                one_hot = '0;
                one_hot[last_id] = 1'b1;
                check("ack_onehot", req_ack, one_hot);
                res_done = give_done;
                if (!hold) begin
                    req_valid = req_valid & ~req_ack;
                end else if (got == n && drop_end) begin
                    req_valid = '0;
                end
            end
        end
        check("serve_acks", got, n);
        tick(1);
        res_done = 1'b0;
        check("ack_pulse", req_ack, 0);
    endtask

    always @(negedge clk) begin : monitor
        logic [REQ_NBITS+DW-1:0] e;
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_issue observed_id=%0d expected=none", res_id);
            end else begin
                e = exp_q.pop_front();
                last_id = e[DW +: REQ_NBITS];
                check("res_id", res_id, e[DW +: REQ_NBITS]);
                check("res_data", res_data, e[DW-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_mask  = '1;
        res_ready = 1'b0;
        res_done  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DW +: DW] = data_of(i);
        end

        // Reset values
        tick(2);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_data", res_data, 0);
        check("rst_ack", req_ack, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_underflow, 0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;

        // Single requester 7: two-cycle latency, ack pulse
        res_ready = 1'b1;
        req_valid[7] = 1'b1;
        push_id(7);
        tick(1);
        check("lat_cycle1_valid", res_valid, 0);
        tick(1);
        check("lat_cycle2_valid", res_valid, 1);
        check("lat_cycle2_id", res_id, 7);
        serve(1, 1'b0, 1'b0, 1'b1);
        check("single_outstanding", outstanding, 0);

        // Pointer now past 7: 10 wins over 3, then wrap to 3
        req_valid[3]  = 1'b1;
        req_valid[10] = 1'b1;
        push_id(10);
        push_id(3);
        serve(2, 1'b0, 1'b0, 1'b1);

        // Reset pointer, then everyone requests continuously
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mptr = 0;
        mburst = 0;
        req_valid = '1;
        for (int k = 0; k < 21; k++) begin
            push_model();
        end
        serve(21, 1'b1, 1'b1, 1'b1);
        check("rr_outstanding", outstanding, 0);

        // Credit limit: four issues, then park in ARB until a completion
        req_valid = '1;
        for (int k = 0; k < MAX_OUT; k++) begin
            push_model();
        end
        serve(MAX_OUT, 1'b1, 1'b0, 1'b0);
        tick(4);
        check("park_state", dbg_state, ARB);
        check("park_outstanding", outstanding, MAX_OUT);
        check("park_valid", res_valid, 0);
        push_model();
        res_done = 1'b1;
        tick(1);
        res_done = 1'b0;
        check("credit_state", dbg_state, ISSUE);
        check("credit_outstanding", outstanding, MAX_OUT - 1);
        serve(1, 1'b1, 1'b1, 1'b1);
        check("fifth_outstanding", outstanding, MAX_OUT - 1);
        res_done = 1'b1;
        tick(MAX_OUT - 1);
        res_done = 1'b0;
        check("drain_outstanding", outstanding, 0);

        // Stall in ISSUE: payload and id held even if input data and mask change
        res_ready = 1'b0;
        req_valid[12] = 1'b1;
        push_id(12);
        tick(2);
        req_data[12*DW +: DW] = ~data_of(12);
        req_mask[12] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("stall_valid", res_valid, 1);
            check("stall_id", res_id, 12);
            check("stall_data", res_data, data_of(12));
            check("stall_ack", req_ack, 0);
        end
        res_ready = 1'b1;
        serve(1, 1'b0, 1'b0, 1'b1);
        req_data[12*DW +: DW] = data_of(12);
        req_mask[12] = 1'b1;

        // Completion with nothing in flight
        res_done = 1'b1;
        tick(1);
        res_done = 1'b0;
        check("uf_err", err_underflow, 1);
        check("uf_outstanding", outstanding, 0);
        tick(3);
        check("uf_sticky", err_underflow, 1);

        // Handshake and completion in the same cycle keep the count
        req_valid[9] = 1'b1;
        push_id(9);
        serve(1, 1'b0, 1'b0, 1'b0);
        check("one_outstanding", outstanding, 1);
        res_ready = 1'b0;
        req_valid[2] = 1'b1;
        push_id(2);
        tick(2);
        check("simul_pre_state", dbg_state, ISSUE);
        res_ready = 1'b1;
        res_done  = 1'b1;
        tick(1);
        res_done  = 1'b0;
        req_valid[2] = 1'b0;
        check("simul_outstanding", outstanding, 1);
        check("simul_ack", req_ack, 1 << 2);
        res_done = 1'b1;
        tick(1);
        res_done = 1'b0;
        check("simul_drain", outstanding, 0);

        // Reset while issuing: request dropped, outputs clear immediately
        res_ready = 1'b0;
        req_valid[5] = 1'b1;
        tick(2);
        check("pre_rst_valid", res_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", res_valid, 0);
        check("arst_id", res_id, 0);
        check("arst_data", res_data, 0);
        check("arst_ack", req_ack, 0);
        check("arst_err", err_underflow, 0);
        check("arst_state", dbg_state, IDLE);
        res_ready = 1'b1;
        tick(2);
        check("arst_hold_ack", req_ack, 0);
        rst = 1'b0;
        req_valid[1] = 1'b1;
        push_id(1);
        push_id(5);
        serve(2, 1'b0, 1'b0, 1'b1);
        check("end_outstanding", outstanding, 0);
        check("end_err", err_underflow, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
